// File: rtl/buyruk_bellegi_hakem_pkg.sv
// Shared definitions for the instruction-memory port arbiter and its response FIFO.
`ifndef BB_ADRES_BIT
`define BB_ADRES_BIT 8
`endif

package buyruk_bellegi_hakem_pkg;
  // The response buffer holds two words, which is enough for one word per cycle
  // across the SRAM's one-cycle read latency.
  localparam int BB_FIFO_DERINLIK = 2;
  localparam int BB_DOLULUK_BIT   = 2;

  typedef logic [31:0] buyruk_t;
endpackage

// File: rtl/buyruk_yanit_fifo.sv
// Two-entry response FIFO for fetched instruction words, with a flush that empties it.
module buyruk_yanit_fifo
  import buyruk_bellegi_hakem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  buyruk_t                   push_veri,
  output buyruk_t                   bas_veri,
  output logic [BB_DOLULUK_BIT-1:0] doluluk
);
  buyruk_t                   mem_q [BB_FIFO_DERINLIK];
  buyruk_t                   mem_d [BB_FIFO_DERINLIK];
  logic                      yaz_ptr_q, yaz_ptr_d;
  logic                      oku_ptr_q, oku_ptr_d;
  logic [BB_DOLULUK_BIT-1:0] sayi_q, sayi_d;

  assign bas_veri = mem_q[oku_ptr_q];
  assign doluluk  = sayi_q;

  // Next pointers, count and storage; a flush discards everything held.
  always_comb begin
    mem_d     = mem_q;
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    if (flush) begin
      yaz_ptr_d = 1'b0;
      oku_ptr_d = 1'b0;
      sayi_d    = '0;
    end else begin
      if (push) begin
        mem_d[yaz_ptr_q] = push_veri;
        yaz_ptr_d        = ~yaz_ptr_q;
      end
      if (pop) begin
        oku_ptr_d = ~oku_ptr_q;
      end
      sayi_d = sayi_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state is reset; the storage words only matter once counted as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yaz_ptr_q <= 1'b0;
      oku_ptr_q <= 1'b0;
      sayi_q    <= '0;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
    end
  end

  // Storage update, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The arbiter's slot rule must never let a word arrive when both entries are taken.
  a_dolu_yazma: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && sayi_q == 2'(BB_FIFO_DERINLIK)));
endmodule

// File: rtl/buyruk_bellegi_hakem.sv
// Shares the instruction-memory SRAM port between fetch reads and loader byte-masked writes.
module buyruk_bellegi_hakem
  import buyruk_bellegi_hakem_pkg::*;
#(
  parameter int ADRES_BIT    = `BB_ADRES_BIT,
  parameter int ACLIK_SINIRI = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 yukle_modu,
  input  logic                 getir_istek_gecerli,
  output logic                 getir_istek_hazir,
  input  logic [ADRES_BIT-1:0] getir_adres,
  input  logic                 getir_iptal,
  output logic                 getir_yanit_gecerli,
  input  logic                 getir_yanit_hazir,
  output logic [31:0]          getir_yanit_veri,
  input  logic                 yukle_istek_gecerli,
  output logic                 yukle_istek_hazir,
  input  logic [ADRES_BIT-1:0] yukle_adres,
  input  logic [31:0]          yukle_veri,
  input  logic [3:0]           yukle_maske,
  output logic                 yukle_bitti,
  output logic                 bb_ena,
  output logic [3:0]           bb_wea,
  output logic [ADRES_BIT-1:0] bb_addra,
  output logic [31:0]          bb_dina,
  input  logic [31:0]          bb_douta
);
  localparam int            AW          = $clog2(ACLIK_SINIRI + 1);
  localparam logic [AW-1:0] ACLIK_TAVAN = AW'(ACLIK_SINIRI);

  logic                      ucusta_q, ucusta_d;
  logic [AW-1:0]             aclik_q, aclik_d;
  logic                      yukle_bitti_q, yukle_bitti_d;
  logic                      yukle_modu_q, yukle_modu_d;
  logic [BB_DOLULUK_BIT-1:0] doluluk;
  logic [2:0]                kapasite;
  logic                      yanit_pop, fifo_push, slot_var;
  logic                      getir_izin, yukle_izin;

  assign getir_yanit_gecerli = (doluluk != '0);
  assign yanit_pop           = getir_yanit_gecerli & getir_yanit_hazir;
  // A read in flight during a flush lands on bb_douta this cycle and is simply not kept.
  assign fifo_push           = ucusta_q & ~getir_iptal;
  assign getir_istek_hazir   = getir_izin;
  assign yukle_istek_hazir   = yukle_izin;
  assign yukle_bitti         = yukle_bitti_q;

  buyruk_yanit_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (yanit_pop),
    .flush     (getir_iptal),
    .push_veri (bb_douta),
    .bas_veri  (getir_yanit_veri),
    .doluluk   (doluluk)
  );

  // Grant decision: fetch wins unless it has no slot or the loader has starved long enough.
  // A flush frees every slot, so a read issued alongside it is always allowed.
  always_comb begin
    kapasite   = {1'b0, doluluk} + {2'b00, ucusta_q} - {2'b00, yanit_pop};
    slot_var   = getir_iptal | (kapasite < 3'd2);
    getir_izin = 1'b0;
    yukle_izin = 1'b0;
    if (!rst) begin
      if (yukle_modu) begin
        yukle_izin = yukle_istek_gecerli;
      end else begin
        getir_izin = getir_istek_gecerli & slot_var &
                     ~(yukle_istek_gecerli & (aclik_q == ACLIK_TAVAN));
        yukle_izin = yukle_istek_gecerli & ~getir_izin;
      end
    end
  end

  // SRAM port drive; an all-zero mask is accepted without touching memory.
  always_comb begin
    bb_ena   = 1'b0;
    bb_wea   = 4'b0000;
    bb_addra = getir_adres;
    bb_dina  = yukle_veri;
    if (getir_izin) begin
      bb_ena = 1'b1;
    end else if (yukle_izin) begin
      bb_ena   = |yukle_maske;
      bb_wea   = yukle_maske;
      bb_addra = yukle_adres;
    end
  end

  // Next-state for read tracking, starvation counter and loader completion pulse.
  always_comb begin
    ucusta_d      = getir_izin;
    yukle_bitti_d = yukle_izin;
    yukle_modu_d  = yukle_modu;
    aclik_d       = aclik_q;
    if (yukle_izin || (yukle_modu_q && !yukle_modu)) begin
      aclik_d = '0;
    end else if (yukle_istek_gecerli && aclik_q != ACLIK_TAVAN) begin
      aclik_d = aclik_q + 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucusta_q      <= 1'b0;
      aclik_q       <= '0;
      yukle_bitti_q <= 1'b0;
      yukle_modu_q  <= 1'b0;
    end else begin
      ucusta_q      <= ucusta_d;
      aclik_q       <= aclik_d;
      yukle_bitti_q <= yukle_bitti_d;
      yukle_modu_q  <= yukle_modu_d;
    end
  end
endmodule

// File: tb/tb_buyruk_bellegi_hakem.sv
// Directed bench for the instruction-memory arbiter with an SRAM model and a response scoreboard.
module tb_buyruk_bellegi_hakem;
  logic        clk = 1'b0;
  logic        rst;
  logic        yukle_modu;
  logic        getir_istek_gecerli;
  logic        getir_istek_hazir;
  logic [7:0]  getir_adres;
  logic        getir_iptal;
  logic        getir_yanit_gecerli;
  logic        getir_yanit_hazir;
  logic [31:0] getir_yanit_veri;
  logic        yukle_istek_gecerli;
  logic        yukle_istek_hazir;
  logic [7:0]  yukle_adres;
  logic [31:0] yukle_veri;
  logic [3:0]  yukle_maske;
  logic        yukle_bitti;
  logic        bb_ena;
  logic [3:0]  bb_wea;
  logic [7:0]  bb_addra;
  logic [31:0] bb_dina;
  logic [31:0] bb_douta;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mem [256];
  logic [31:0] beklenen_q [$];

  buyruk_bellegi_hakem #(.ADRES_BIT(8), .ACLIK_SINIRI(4)) dut (
    .clk(clk), .rst(rst), .yukle_modu(yukle_modu),
    .getir_istek_gecerli(getir_istek_gecerli), .getir_istek_hazir(getir_istek_hazir),
    .getir_adres(getir_adres), .getir_iptal(getir_iptal),
    .getir_yanit_gecerli(getir_yanit_gecerli), .getir_yanit_hazir(getir_yanit_hazir),
    .getir_yanit_veri(getir_yanit_veri),
    .yukle_istek_gecerli(yukle_istek_gecerli), .yukle_istek_hazir(yukle_istek_hazir),
    .yukle_adres(yukle_adres), .yukle_veri(yukle_veri), .yukle_maske(yukle_maske),
    .yukle_bitti(yukle_bitti),
    .bb_ena(bb_ena), .bb_wea(bb_wea), .bb_addra(bb_addra), .bb_dina(bb_dina),
    .bb_douta(bb_douta)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] kelime(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {8'hC3, b, ~b, b ^ 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SRAM model: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (bb_ena) begin
      if (bb_wea == 4'b0000) bb_douta <= mem[bb_addra];
      else for (int b = 0; b < 4; b++) if (bb_wea[b]) mem[bb_addra][8*b +: 8] <= bb_dina[8*b +: 8];
    end
  end

  // Scoreboard: expected word queued at grant, compared when consumed, dropped on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      beklenen_q.delete();
    end else begin
      if (getir_yanit_gecerli && getir_yanit_hazir) begin
        if (beklenen_q.size() == 0) chk("unexpected_response", getir_yanit_veri, 32'h0);
        else chk("response_data", getir_yanit_veri, beklenen_q.pop_front());
      end
      if (getir_iptal) beklenen_q.delete();
      if (getir_istek_gecerli && getir_istek_hazir) beklenen_q.push_back(mem[getir_adres]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa;
    for (int i = 0; i < 256; i++) mem[i] = kelime(i);
    rst = 1'b1; yukle_modu = 1'b0; getir_istek_gecerli = 1'b1; getir_adres = 8'h00;
    getir_iptal = 1'b0; getir_yanit_hazir = 1'b1; yukle_istek_gecerli = 1'b1;
    yukle_adres = 8'h00; yukle_veri = 32'h0; yukle_maske = 4'hF;

    // Reset state with requests pending
    @(negedge clk);
    chk("rst_getir_hazir", getir_istek_hazir, 1'b0);
    chk("rst_yukle_hazir", yukle_istek_hazir, 1'b0);
    chk("rst_bb_ena", bb_ena, 1'b0);
    chk("rst_bb_wea", bb_wea, 4'b0000);
    step(); rst = 1'b0; getir_istek_gecerli = 1'b0; yukle_istek_gecerli = 1'b0;
    @(negedge clk);
    chk("post_rst_yanit", getir_yanit_gecerli, 1'b0);
    chk("post_rst_bitti", yukle_bitti, 1'b0);

    // Test 1: reset during an in-flight read
    step(); getir_istek_gecerli = 1'b1; getir_adres = 8'h05;
    @(negedge clk);
    chk("t1_grant", getir_istek_hazir, 1'b1);
    step(); getir_adres = 8'h06;
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_bb_ena", bb_ena, 1'b0);
    chk("t1_rst_grant", getir_istek_hazir, 1'b0);
    step(); rst = 1'b0; getir_istek_gecerli = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_no_response", getir_yanit_gecerli, 1'b0);
      step();
    end

    // Test 2: back-to-back fetch 0x10..0x13, first response at N+2
    for (int i = 0; i < 4; i++) begin
      getir_istek_gecerli = 1'b1; getir_adres = 8'(8'h10 + i);
      @(negedge clk);
      chk("t2_grant", getir_istek_hazir, 1'b1);
      chk("t2_bb_addra", bb_addra, 8'(8'h10 + i));
      chk("t2_resp_latency", getir_yanit_gecerli, (i >= 2));
      step();
    end
    getir_istek_gecerli = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Test 3: consumer stalls, only two reads outstanding, none lost on resume
    getir_yanit_hazir = 1'b0; fa = 8'h60;
    for (int k = 0; k < 5; k++) begin
      getir_istek_gecerli = 1'b1; getir_adres = fa;
      @(negedge clk);
      chk("t3_stall_grant", getir_istek_hazir, (k < 2));
      if (k < 2) fa++;
      step();
    end
    getir_yanit_hazir = 1'b1;
    for (int k = 0; k < 6; k++) begin
      getir_adres = fa;
      @(negedge clk);
      chk("t3_resume_grant", getir_istek_hazir, 1'b1);
      fa++;
      step();
    end
    getir_istek_gecerli = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Test 4: loader starvation limit with continuous fetch
    fa = 8'h70; yukle_istek_gecerli = 1'b1; yukle_adres = 8'h30;
    yukle_veri = 32'h1234_5678; yukle_maske = 4'hF;
    for (int k = 0; k < 10; k++) begin
      getir_istek_gecerli = 1'b1; getir_adres = fa;
      @(negedge clk);
      chk("t4_loader_grant", yukle_istek_hazir, (k == 4 || k == 9));
      chk("t4_fetch_grant", getir_istek_hazir, !(k == 4 || k == 9));
      chk("t4_bitti", yukle_bitti, (k == 5));
      if (k == 4) chk("t4_bb_wea", bb_wea, 4'hF);
      if (!(k == 4 || k == 9)) fa++;
      step();
    end
    getir_istek_gecerli = 1'b0; yukle_istek_gecerli = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Test 5: loader mode, masked write then zero-mask write
    yukle_modu = 1'b1; getir_istek_gecerli = 1'b1; getir_adres = 8'h11;
    yukle_istek_gecerli = 1'b1; yukle_adres = 8'h20; yukle_veri = 32'hDEAD_BEEF; yukle_maske = 4'b0011;
    @(negedge clk);
    chk("t5_fetch_blocked", getir_istek_hazir, 1'b0);
    chk("t5_grant1", yukle_istek_hazir, 1'b1);
    chk("t5_ena1", bb_ena, 1'b1);
    chk("t5_wea1", bb_wea, 4'b0011);
    chk("t5_addr1", bb_addra, 8'h20);
    chk("t5_dina1", bb_dina, 32'hDEAD_BEEF);
    step(); yukle_maske = 4'b0000; yukle_adres = 8'h21;
    @(negedge clk);
    chk("t5_grant2", yukle_istek_hazir, 1'b1);
    chk("t5_ena2", bb_ena, 1'b0);
    chk("t5_wea2", bb_wea, 4'b0000);
    chk("t5_bitti1", yukle_bitti, 1'b1);
    step(); yukle_istek_gecerli = 1'b0; getir_istek_gecerli = 1'b0;
    @(negedge clk);
    chk("t5_bitti2", yukle_bitti, 1'b1);
    step();
    @(negedge clk);
    chk("t5_bitti_end", yukle_bitti, 1'b0);
    chk("t5_mem20", mem[8'h20], {kelime(8'h20) >> 16, 16'hBEEF});
    chk("t5_mem21", mem[8'h21], kelime(8'h21));
    yukle_modu = 1'b0;
    step(); getir_istek_gecerli = 1'b1; getir_adres = 8'h20;
    step(); getir_istek_gecerli = 1'b0;
    step();
    @(negedge clk);
    chk("t5_readback", getir_yanit_veri, {kelime(8'h20) >> 16, 16'hBEEF});
    for (int i = 0; i < 3; i++) step();

    // Test 6a: flush with two buffered words and a new grant to 0x40
    getir_yanit_hazir = 1'b0; getir_istek_gecerli = 1'b1; getir_adres = 8'h41;
    step(); getir_adres = 8'h42;
    step(); getir_istek_gecerli = 1'b0;
    step();
    getir_iptal = 1'b1; getir_istek_gecerli = 1'b1; getir_adres = 8'h40;
    @(negedge clk);
    chk("t6a_full_before", getir_yanit_gecerli, 1'b1);
    chk("t6a_grant_on_flush", getir_istek_hazir, 1'b1);
    step(); getir_iptal = 1'b0; getir_istek_gecerli = 1'b0; getir_yanit_hazir = 1'b1;
    @(negedge clk);
    chk("t6a_empty_after", getir_yanit_gecerli, 1'b0);
    step();
    @(negedge clk);
    chk("t6a_resp_valid", getir_yanit_gecerli, 1'b1);
    chk("t6a_resp_data", getir_yanit_veri, kelime(8'h40));
    step();
    @(negedge clk);
    chk("t6a_only_one", getir_yanit_gecerli, 1'b0);

    // Test 6b: flush with one buffered word, one read in flight, and a new grant to 0x40
    step(); getir_yanit_hazir = 1'b0; getir_istek_gecerli = 1'b1; getir_adres = 8'h44;
    step(); getir_adres = 8'h45;
    step(); getir_iptal = 1'b1; getir_adres = 8'h40;
    @(negedge clk);
    chk("t6b_grant_on_flush", getir_istek_hazir, 1'b1);
    step(); getir_iptal = 1'b0; getir_istek_gecerli = 1'b0; getir_yanit_hazir = 1'b1;
    @(negedge clk);
    chk("t6b_inflight_dropped", getir_yanit_gecerli, 1'b0);
    step();
    @(negedge clk);
    chk("t6b_resp_valid", getir_yanit_gecerli, 1'b1);
    chk("t6b_resp_data", getir_yanit_veri, kelime(8'h40));
    step();
    @(negedge clk);
    chk("t6b_only_one", getir_yanit_gecerli, 1'b0);

    step(); step();
    chk("scoreboard_drained", beklenen_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
